// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared segment patterns and BCD digit type for the 7-segment scanner
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD nibble to active-high 7-segment pattern
module bcd_to_7seg
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - double-buffered multiplexed 7-segment scanner for packed BCD words
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_seg_scanner
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    bcd_err
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    full_q, full_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    err_q, err_d;

  bcd_digit_t            cur_digit;
  logic [NUM_DIGITS-1:0] an_hot;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_hi;
  logic                  blank;
  logic                  zero_run;
  logic                  tc;
  logic                  frame_end;
  logic                  accept;
  logic                  bad_nibble;

  always_comb begin
    cur_digit = '0;
    an_hot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        an_hot[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; blank while every digit seen so far is zero.
  always_comb begin
    zero_run = 1'b1;
    blank    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_q[4*i +: 4] == 4'd0);
      if ((i != 0) && (idx_q == IDX_W'(i)) && zero_run) begin
        blank = 1'b1;
      end
    end
  end
`else
  always_comb begin
    zero_run = 1'b0;
    blank    = zero_run;
  end
`endif

  bcd_to_7seg u_dec (
    .digit_i (cur_digit),
    .seg_o   (dec_seg)
  );

  assign seg_hi = blank ? SEG_OFF : dec_seg;

  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_nibble = 1'b1;
      end
    end
  end

  assign tc        = (cnt_q == CNT_LAST);
  assign frame_end = tc && (idx_q == IDX_LAST);
  assign accept    = in_valid && !full_q;

  always_comb begin
    cnt_d  = tc ? '0 : cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    disp_d = disp_q;
    pend_d = pend_q;
    full_d = full_q;
    if (tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    // Swap only at the frame boundary so a frame never mixes two words.
    if (frame_end && full_q) begin
      disp_d = pend_q;
      full_d = 1'b0;
    end else if (accept) begin
      pend_d = bcd_in;
      full_d = 1'b1;
    end
    err_d = accept && bad_nibble;
    seg_d = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    an_d  = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      pend_q <= '0;
      full_q <= 1'b0;
      seg_q  <= SEG_IDLE;
      an_q   <= AN_IDLE;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      full_q <= full_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      err_q  <= err_d;
    end
  end

  assign in_ready = !full_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign bcd_err  = err_q;

endmodule
